seg7_to_bcd_reader: RTL and testbench
=====================================

Name: seg7_to_bcd_reader

Overview:
- Inverse of the team's BCD-to-7-segment decoder: samples an active-low 7-segment bus, filters glitches, and recovers the BCD digit.
- Used to read back display drivers (loopback self-test) and to ingest segment buses from external boards.
- Delivers one valid/ready transaction per distinct stable pattern, and flags illegal patterns.

Parameters:
- WORD_LENGTH, 4, width of bcd_out.
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (legal range 2..15).
- CNT_WIDTH, 4, stability counter width; must hold STABLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = track the input; 0 = freeze the stability counter and start no new transactions.
- segmentos_in  input  7  active-low segments, bit6..bit0 = g,f,e,d,c,b,a.
- bcd_ready  input  1  consumer accepts the transaction on an edge where bcd_valid && bcd_ready.
- bcd_out  output  WORD_LENGTH  recovered digit 0..9; 4'b1111 on error.
- bcd_valid  output  1  transaction pending.
- error_flag  output  1  qualifies the current transaction: the pattern was stable but illegal.
- blank  output  1  level signal: the current stable pattern is 7'b1111111.
- overrun  output  1  sticky: a new distinct pattern stabilised while a transaction was pending.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - All outputs are 0, state = S_TRACK, counter = 0, sample register = 7'b1111111.
  - last_reported = 7'b1111111, so a blank display after reset produces no transaction.
- Input stage: segmentos_in is registered into s_q on every edge; no other logic uses the raw input.
- Stability counter (while enable = 1):
  - If the new sample equals s_q, cnt increments, saturating at STABLE_CYCLES.
  - Otherwise cnt loads 1.
  - enable = 0 holds cnt at 0.
- stable = (cnt == STABLE_CYCLES).
- Lookup (combinational) for legal digits:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0011000.
  - 1111111 = blank.
  - Any other pattern is illegal.
- blank: registered; set to 1 when stable && s_q == 7'b1111111, cleared when cnt leaves stable. It never generates a transaction.
- FSM state S_TRACK: on an edge where stable && s_q != last_reported && s_q is not blank:
  - load bcd_out (the digit, or 4'b1111 if illegal) and error_flag (1 if illegal);
  - set last_reported = s_q, bcd_valid = 1, and go to S_PRESENT.
- FSM state S_PRESENT:
  - bcd_out, error_flag and bcd_valid are held.
  - On an edge where bcd_ready = 1: bcd_valid goes to 0 and the FSM returns to S_TRACK.
  - Tracking continues in this state. If stable && s_q != last_reported (and s_q is not blank), overrun is set; that pattern is reported after the handshake if it is still stable.
- Latency: a pattern held constant and first sampled at edge k gives bcd_valid = 1 after edge k + STABLE_CYCLES (5 edges after it first appears on segmentos_in with the default STABLE_CYCLES).
- Throughput: a handshake edge always returns to S_TRACK, so there is at least one bcd_valid = 0 cycle between transactions.
- Boundary conditions:
  - Glitch shorter than STABLE_CYCLES: no transaction, and last_reported is unchanged.
  - Same digit re-stabilises after a glitch: no new transaction.
  - Digit → blank → same digit: no new transaction, because blank does not update last_reported.
  - enable dropped in S_PRESENT: the pending transaction still completes.
  - reset asserted in S_PRESENT: bcd_valid = 0 on that edge and the transaction is lost.
  - bcd_ready while bcd_valid = 0: ignored.

Decomposition:
- Shared package (seg7_pkg):
  - active-low segment constants SEG_0..SEG_9 and SEG_BLANK;
  - BCD_ERR = 4'b1111;
  - FSM state encoding S_TRACK/S_PRESENT.
- The same SEG_* constants also serve the existing decoder.
- Sub-module seg7_pattern_lookup: purely combational, pattern → {bcd, is_digit, is_blank}.
- Top level holds the sampling register, stability counter, FSM and handshake.

Test Plan:
- Reset, then hold 0100100 for 10 cycles with bcd_ready = 1 → bcd_valid pulses for exactly one cycle, 5 edges after the input is applied, with bcd_out = 2 and error_flag = 0.
- Hold 1111001, then a 2-cycle glitch to 0000000, then back to 1111001 → exactly one transaction (bcd_out = 1), no transaction for 8, and overrun = 0.
- Stable 0011111 (illegal) → bcd_valid = 1, error_flag = 1, bcd_out = 4'b1111.
- bcd_ready = 0 with 7 (1111000) stable, then 9 (0011000) stable → bcd_out stays 7 and overrun = 1. Raising bcd_ready → transaction 7 completes, a bubble cycle follows, then a transaction with bcd_out = 9.
- Stable 1111111 after reset → no bcd_valid, blank = 1. Then 0 (1000000) → blank = 0 and a transaction with bcd_out = 0.
- Assert reset while bcd_valid = 1 with bcd_out = 5 → all outputs 0 on the next edge, overrun cleared, and 5 is reported again once it has been stable for 5 edges.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns, BCD error code, reader FSM states.
package seg7_pkg;

  localparam int unsigned SEG_WIDTH = 7;
  localparam int unsigned BCD_WIDTH = 4;

  // Active-low patterns, bit6..bit0 = g,f,e,d,c,b,a
  localparam logic [SEG_WIDTH-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_WIDTH-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_WIDTH-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_WIDTH-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_WIDTH-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_WIDTH-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_WIDTH-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_WIDTH-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_WIDTH-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_WIDTH-1:0] SEG_9     = 7'b0011000;
  localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [BCD_WIDTH-1:0] BCD_ERR = 4'b1111;

  typedef enum logic {
    S_TRACK   = 1'b0,
    S_PRESENT = 1'b1
  } reader_state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational decode of an active-low 7-segment pattern into a BCD digit plus legality flags.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] bcd,
  output logic       is_digit,
  output logic       is_blank
);

  // Pattern match; anything not a digit or blank is illegal and reports BCD_ERR
  always_comb begin
    bcd      = BCD_ERR;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_bcd_reader.sv
// Samples an active-low 7-segment bus, waits for a stable pattern and reports it once
// over a valid/ready handshake, flagging illegal patterns and missed updates.
module seg7_to_bcd_reader
  import seg7_pkg::*;
#(
  parameter int unsigned WORD_LENGTH   = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [6:0]             segmentos_in,
  input  logic                   bcd_ready,
  output logic [WORD_LENGTH-1:0] bcd_out,
  output logic                   bcd_valid,
  output logic                   error_flag,
  output logic                   blank,
  output logic                   overrun
);

  logic [6:0]           s_q;
  logic [6:0]           last_reported;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 stable;
  logic [3:0]           lk_bcd;
  logic                 lk_is_digit;
  logic                 lk_is_blank;
  logic                 new_pattern;
  reader_state_t        state;

  seg7_pattern_lookup u_lookup (
    .pattern  (s_q),
    .bcd      (lk_bcd),
    .is_digit (lk_is_digit),
    .is_blank (lk_is_blank)
  );

  assign stable      = (cnt == CNT_WIDTH'(STABLE_CYCLES));
  assign new_pattern = enable && stable && !lk_is_blank && (s_q != last_reported);

  // Input sampling register; the raw bus is used nowhere else
  always_ff @(posedge clk) begin
    if (reset) s_q <= SEG_BLANK;
    else       s_q <= segmentos_in;
  end

  // Stability counter: counts consecutive identical samples, saturating once stable
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (segmentos_in == s_q) begin
      if (!stable) cnt <= cnt + CNT_WIDTH'(1);
    end else begin
      cnt <= CNT_WIDTH'(1);
    end
  end

  // Blank indicator follows the stable pattern and never starts a transaction
  always_ff @(posedge clk) begin
    if (reset) blank <= 1'b0;
    else       blank <= stable && lk_is_blank;
  end

  // Report FSM: capture a new stable pattern, hold it until the handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_TRACK;
      bcd_out       <= '0;
      error_flag    <= 1'b0;
      bcd_valid     <= 1'b0;
      overrun       <= 1'b0;
      last_reported <= SEG_BLANK;
    end else begin
      case (state)
        S_TRACK: begin
          if (new_pattern) begin
            bcd_out       <= lk_is_digit ? WORD_LENGTH'(lk_bcd) : {WORD_LENGTH{1'b1}};
            error_flag    <= !lk_is_digit;
            last_reported <= s_q;
            bcd_valid     <= 1'b1;
            state         <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // A different pattern settling while we wait is lost unless it is still there later
          if (new_pattern) overrun <= 1'b1;
          if (bcd_ready) begin
            bcd_valid <= 1'b0;
            state     <= S_TRACK;
          end
        end
        default: state <= S_TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_to_bcd_reader.sv
// Directed bench for seg7_to_bcd_reader with a scoreboard queue and a handshake monitor.
module tb_seg7_to_bcd_reader;

  typedef struct packed {
    logic [3:0] bcd;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [6:0] seg;
  logic       bcd_ready;
  logic [3:0] bcd_out;
  logic       bcd_valid;
  logic       error_flag;
  logic       blank;
  logic       overrun;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  seg7_to_bcd_reader #(
    .WORD_LENGTH   (4),
    .STABLE_CYCLES (4),
    .CNT_WIDTH     (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .segmentos_in (seg),
    .bcd_ready    (bcd_ready),
    .bcd_out      (bcd_out),
    .bcd_valid    (bcd_valid),
    .error_flag   (error_flag),
    .blank        (blank),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] b, input logic e);
    exp_t x;
    x.bcd = b;
    x.err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: every handshake must match the oldest expected transaction
  always @(negedge clk) begin
    if (!reset && bcd_valid && bcd_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_txn", {28'd0, bcd_out}, 32'hdead);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("txn_bcd", {28'd0, bcd_out}, {28'd0, e.bcd});
        check("txn_err", {31'd0, error_flag}, {31'd0, e.err});
      end
    end
  end

  initial begin
    exp_t dropped;
    reset     = 1'b1;
    enable    = 1'b1;
    seg       = 7'b1111111;
    bcd_ready = 1'b1;
    tick(3);
    check("rst_valid",   {31'd0, bcd_valid},  32'd0);
    check("rst_bcd",     {28'd0, bcd_out},    32'd0);
    check("rst_err",     {31'd0, error_flag}, 32'd0);
    check("rst_blank",   {31'd0, blank},      32'd0);
    check("rst_overrun", {31'd0, overrun},    32'd0);
    reset = 1'b0;

    // Digit 2: latency of 5 edges, one-cycle pulse with ready high
    seg = 7'b0100100;
    push(4'd2, 1'b0);
    tick(4);
    check("lat_early", {31'd0, bcd_valid}, 32'd0);
    tick(1);
    check("lat_valid", {31'd0, bcd_valid}, 32'd1);
    check("lat_bcd",   {28'd0, bcd_out},   32'd2);
    tick(1);
    check("pulse_width", {31'd0, bcd_valid}, 32'd0);
    tick(4);

    // Digit 1 with a 2-cycle glitch to 8: single transaction
    seg = 7'b1111001;
    push(4'd1, 1'b0);
    tick(8);
    seg = 7'b0000000;
    tick(2);
    seg = 7'b1111001;
    tick(8);
    check("glitch_overrun", {31'd0, overrun}, 32'd0);

    // Illegal pattern
    seg = 7'b0011111;
    push(4'hf, 1'b1);
    tick(5);
    check("illegal_valid", {31'd0, bcd_valid},  32'd1);
    check("illegal_err",   {31'd0, error_flag}, 32'd1);
    check("illegal_bcd",   {28'd0, bcd_out},    32'hf);
    tick(3);

    // Backpressure: 7 pending while 9 stabilises
    bcd_ready = 1'b0;
    seg = 7'b1111000;
    push(4'd7, 1'b0);
    tick(8);
    check("bp_valid", {31'd0, bcd_valid}, 32'd1);
    check("bp_bcd7",  {28'd0, bcd_out},   32'd7);
    seg = 7'b0011000;
    tick(8);
    check("bp_hold7",  {28'd0, bcd_out},  32'd7);
    check("bp_overrun", {31'd0, overrun}, 32'd1);
    push(4'd9, 1'b0);
    bcd_ready = 1'b1;
    tick(1);
    check("bubble", {31'd0, bcd_valid}, 32'd0);
    tick(1);
    check("after_bubble_valid", {31'd0, bcd_valid}, 32'd1);
    check("after_bubble_bcd",   {28'd0, bcd_out},   32'd9);
    tick(2);

    // Blank after reset, then 0
    reset = 1'b1;
    seg   = 7'b1111111;
    tick(1);
    reset = 1'b0;
    tick(8);
    check("blank_set",     {31'd0, blank},     32'd1);
    check("blank_novalid", {31'd0, bcd_valid}, 32'd0);
    seg = 7'b1000000;
    push(4'd0, 1'b0);
    tick(3);
    check("blank_clear", {31'd0, blank}, 32'd0);
    tick(6);

    // Reset while 5 is pending with overrun set
    bcd_ready = 1'b0;
    seg = 7'b0010010;
    push(4'd5, 1'b0);
    tick(8);
    check("pend5_bcd", {28'd0, bcd_out}, 32'd5);
    seg = 7'b0000010;
    tick(8);
    check("pend5_overrun", {31'd0, overrun}, 32'd1);
    seg = 7'b0010010;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("rst2_valid",   {31'd0, bcd_valid},  32'd0);
    check("rst2_bcd",     {28'd0, bcd_out},    32'd0);
    check("rst2_err",     {31'd0, error_flag}, 32'd0);
    check("rst2_overrun", {31'd0, overrun},    32'd0);
    dropped = exp_q.pop_front();
    reset = 1'b0;
    bcd_ready = 1'b1;
    push(4'd5, 1'b0);
    tick(4);
    check("re5_early", {31'd0, bcd_valid}, 32'd0);
    tick(1);
    check("re5_valid", {31'd0, bcd_valid}, 32'd1);
    check("re5_bcd",   {28'd0, bcd_out},   32'd5);
    tick(3);

    // Digit -> blank -> same digit: no new transaction
    seg = 7'b1111111;
    tick(8);
    check("dbd_blank", {31'd0, blank}, 32'd1);
    seg = 7'b0010010;
    tick(8);
    check("dbd_novalid", {31'd0, bcd_valid}, 32'd0);

    // enable dropped while presenting: transaction still completes
    bcd_ready = 1'b0;
    seg = 7'b0110000;
    push(4'd3, 1'b0);
    tick(8);
    enable = 1'b0;
    tick(3);
    check("en_hold_valid", {31'd0, bcd_valid}, 32'd1);
    check("en_hold_bcd",   {28'd0, bcd_out},   32'd3);
    bcd_ready = 1'b1;
    tick(1);
    check("en_done", {31'd0, bcd_valid}, 32'd0);
    enable = 1'b1;
    tick(8);
    check("en_norepeat", {31'd0, bcd_valid}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
